sum_mixer: RTL and testbench



---
 rtl/sum_mixer_if.sv | 13 +
 rtl/sum_mixer.sv | 196 +++++++++++++++++++
 tb/tb_sum_mixer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_mixer_if.sv
// Register bus between the PS and sum_mixer: byte address, one-cycle strobes,
// registered acknowledge and read data.
interface sum_mixer_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] wdata;

  modport master (output addr, wen, ren, wdata, input ack, rdata);
  modport slave  (input addr, wen, ren, wdata, output ack, rdata);
endinterface

// File: rtl/sum_mixer.sv
// N-channel signed summing stage: enable/negate, pipelined adder tree, shift, saturate.
// Optional saturation-event counter at 0x0C built when SUM_MIXER_SATCNT_EN is defined.
module sum_mixer #(
  parameter int N_CH      = 2,
  parameter int DW        = 14,
  parameter int SHIFT_RST = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH*DW-1:0]     in_i,
  input  logic                   in_valid_i,
  output logic signed [DW-1:0]   out_o,
  output logic                   out_valid_o,
  output logic                   sat_o,
  sum_mixer_if.slave             bus
);

  localparam int LV = $clog2(N_CH);
  localparam int SW = DW + 1 + LV;
  localparam int NV = LV + 3;

  typedef logic signed [SW-1:0] word_t;

  localparam word_t MAXV = word_t'((1 << (DW - 1)) - 1);
  localparam word_t MINV = ~MAXV;

  function automatic int level_cnt(input int l);
    return (N_CH + (1 << l) - 1) >> l;
  endfunction

  logic [N_CH-1:0]       en_q, en_d;
  logic [N_CH-1:0]       neg_q, neg_d;
  logic [3:0]            shift_q, shift_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           rd_val;
  logic [2:0]            reg_idx;

  // Level 0 holds the conditioned channels; level l holds the l-th adder level.
  word_t                 tree_q [LV+1][N_CH];
  word_t                 tree_d [LV+1][N_CH];
  logic [3:0]            sh_q [LV+1];
  logic [3:0]            sh_d [LV+1];
  word_t                 shr_q, shr_d;
  logic signed [DW-1:0]  out_q, out_d;
  logic                  sat_q, sat_d;
  logic [NV-1:0]         vld_q, vld_d;

  logic                  unused_bits;
  assign unused_bits = ^{bus.addr, bus.wdata};

  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      for (int j = 0; j < N_CH; j++) begin
        tree_d[l][j] = '0;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (en_q[k]) begin
        tree_d[0][k] = neg_q[k] ? -word_t'($signed(in_i[k*DW +: DW]))
                                :  word_t'($signed(in_i[k*DW +: DW]));
      end
    end
    for (int l = 1; l <= LV; l++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (j < level_cnt(l)) begin
          if (2*j + 1 < level_cnt(l - 1)) begin
            tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
          end else begin
            tree_d[l][j] = tree_q[l-1][2*j];
          end
        end
      end
    end

    sh_d[0] = shift_q;
    for (int l = 1; l <= LV; l++) begin
      sh_d[l] = sh_q[l-1];
    end

    shr_d = tree_q[LV][0] >>> sh_q[LV];

    sat_d = 1'b0;
    out_d = shr_q[DW-1:0];
    if (shr_q > MAXV) begin
      sat_d = 1'b1;
      out_d = MAXV[DW-1:0];
    end else if (shr_q < MINV) begin
      sat_d = 1'b1;
      out_d = MINV[DW-1:0];
    end

    vld_d = {vld_q[NV-2:0], in_valid_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int l = 0; l <= LV; l++) begin
        sh_q[l] <= '0;
        for (int j = 0; j < N_CH; j++) begin
          tree_q[l][j] <= '0;
        end
      end
      shr_q <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
      vld_q <= '0;
    end else begin
      for (int l = 0; l <= LV; l++) begin
        sh_q[l] <= sh_d[l];
        for (int j = 0; j < N_CH; j++) begin
          tree_q[l][j] <= tree_d[l][j];
        end
      end
      shr_q <= shr_d;
      out_q <= out_d;
      sat_q <= sat_d;
      vld_q <= vld_d;
    end
  end

  assign out_o       = out_q;
  assign sat_o       = sat_q;
  assign out_valid_o = vld_q[NV-1];

`ifdef SUM_MIXER_SATCNT_EN
  logic [31:0] satcnt_q, satcnt_d;

  // A clear wins over a coinciding increment; the count sticks at all ones.
  always_comb begin
    satcnt_d = satcnt_q;
    if (bus.wen && reg_idx == 3'd3) begin
      satcnt_d = '0;
    end else if (out_valid_o && sat_o && satcnt_q != '1) begin
      satcnt_d = satcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      satcnt_q <= '0;
    end else begin
      satcnt_q <= satcnt_d;
    end
  end
`endif

  always_comb begin
    reg_idx = bus.addr[4:2];
    en_d    = en_q;
    neg_d   = neg_q;
    shift_d = shift_q;
    if (bus.wen) begin
      case (reg_idx)
        3'd0:    en_d    = bus.wdata[N_CH-1:0];
        3'd1:    neg_d   = bus.wdata[N_CH-1:0];
        3'd2:    shift_d = bus.wdata[3:0];
        default: ;
      endcase
    end

    rd_val = '0;
    case (reg_idx)
      3'd0:    rd_val[N_CH-1:0] = en_q;
      3'd1:    rd_val[N_CH-1:0] = neg_q;
      3'd2:    rd_val[3:0]      = shift_q;
`ifdef SUM_MIXER_SATCNT_EN
      3'd3:    rd_val           = satcnt_q;
`endif
      default: ;
    endcase

    rdata_d = bus.ren ? rd_val : rdata_q;
    ack_d   = bus.wen | bus.ren;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q    <= '1;
      neg_q   <= '0;
      shift_q <= 4'(SHIFT_RST);
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      neg_q   <= neg_d;
      shift_q <= shift_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sum_mixer.sv
// Randomised bench for sum_mixer (N_CH=2, DW=14) against an arithmetic reference
// model; follows SUM_MIXER_SATCNT_EN for the expected counter behaviour.
module tb_sum_mixer;
  localparam int N_CH = 2;
  localparam int DW   = 14;
  localparam int L    = 3;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [N_CH*DW-1:0]    in_i;
  logic                  in_valid_i;
  logic signed [DW-1:0]  out_o;
  logic                  out_valid_o;
  logic                  sat_o;

  sum_mixer_if bus ();

  always #5 clk_i = ~clk_i;

  sum_mixer #(.N_CH(N_CH), .DW(DW), .SHIFT_RST(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_i        (in_i),
    .in_valid_i  (in_valid_i),
    .out_o       (out_o),
    .out_valid_o (out_valid_o),
    .sat_o       (sat_o),
    .bus         (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit v;
    int val;
    bit sat;
  } exp_t;

  exp_t        pipe_m[$];
  logic [1:0]  en_m, neg_m;
  int          shift_m;
  logic [31:0] satcnt_m;
  bit          ack_m;
  logic [31:0] rdata_m;
  bit          cur_v, cur_sat;

  function automatic exp_t model_sample(input int a, input int b, input bit v);
    exp_t e;
    int   ch[2];
    int   s;
    ch[0] = a;
    ch[1] = b;
    s = 0;
    for (int k = 0; k < 2; k++) begin
      if (en_m[k]) s += neg_m[k] ? -ch[k] : ch[k];
    end
    s = s >>> shift_m;
    e.v   = v;
    e.sat = (s > 8191) || (s < -8192);
    e.val = (s > 8191) ? 8191 : (s < -8192) ? -8192 : s;
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] ad);
    logic [31:0] r;
    r = '0;
    case (ad[4:2])
      3'd0: r = {30'd0, en_m};
      3'd1: r = {30'd0, neg_m};
      3'd2: r = 32'(shift_m);
`ifdef SUM_MIXER_SATCNT_EN
      3'd3: r = satcnt_m;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    en_m     = 2'b11;
    neg_m    = 2'b00;
    shift_m  = 1;
    satcnt_m = '0;
    ack_m    = 1'b0;
    rdata_m  = '0;
    cur_v    = 1'b0;
    cur_sat  = 1'b0;
    pipe_m.delete();
    repeat (L) pipe_m.push_back('{v: 1'b0, val: 0, sat: 1'b0});
  endtask

  // One clock: drive inputs/bus, advance the model, check outputs after the edge.
  task automatic step(input int a, input int b, input bit v, input bit w, input bit r,
                      input logic [15:0] ad, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] rv;
    in_i       = {b[13:0], a[13:0]};
    in_valid_i = v;
    bus.wen    = w;
    bus.ren    = r;
    bus.addr   = ad;
    bus.wdata  = wd;

    pipe_m.push_back(model_sample(a, b, v));
    rv = model_read(ad);
`ifdef SUM_MIXER_SATCNT_EN
    if (w && ad[4:2] == 3'd3) satcnt_m = '0;
    else if (cur_v && cur_sat && satcnt_m != 32'hFFFF_FFFF) satcnt_m = satcnt_m + 32'd1;
`endif
    if (w) begin
      case (ad[4:2])
        3'd0: en_m = wd[1:0];
        3'd1: neg_m = wd[1:0];
        3'd2: shift_m = int'(wd[3:0]);
        default: ;
      endcase
    end
    ack_m = w | r;
    if (r) rdata_m = rv;

    @(posedge clk_i);
    #1;
    e = pipe_m.pop_front();
    check_eq("out_valid", out_valid_o, e.v);
    if (e.v) begin
      check_eq("out", out_o, e.val);
      check_eq("sat", sat_o, e.sat);
    end
    cur_v   = e.v;
    cur_sat = e.sat;
    check_eq("ack", bus.ack, ack_m);
    check_eq("rdata", bus.rdata, rdata_m);
  endtask

  task automatic sample(input int a, input int b);
    step(a, b, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] ad, input logic [31:0] wd);
    step(0, 0, 1'b0, 1'b1, 1'b0, ad, wd);
  endtask

  task automatic rd(input logic [15:0] ad);
    step(0, 0, 1'b0, 1'b0, 1'b1, ad, 32'h0);
  endtask

  function automatic int rand_sample();
    int x;
    case ($urandom_range(0, 5))
      0:       x = 8191;
      1:       x = -8192;
      default: x = int'($urandom_range(0, 16383)) - 8192;
    endcase
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out"}, out_o, 0);
    check_eq({tag, "_valid"}, out_valid_o, 0);
    check_eq({tag, "_sat"}, sat_o, 0);
    check_eq({tag, "_ack"}, bus.ack, 0);
    check_eq({tag, "_rdata"}, bus.rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    in_i       = '0;
    in_valid_i = 1'b0;
    bus.wen    = 1'b0;
    bus.ren    = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Defaults: EN=11, NEG=00, SHIFT=1 -> (1000+2000)>>1
    sample(1000, 2000);
    idle(4);
    rd(16'h00); rd(16'h04); rd(16'h08); rd(16'h0C);

    // Positive saturation
    wr(16'h08, 32'd0);
    sample(8191, 8191);
    idle(4);
    rd(16'h0C);

    // Negation at full scale, with and without shift
    wr(16'h04, 32'd2);
    sample(5000, -8192);
    wr(16'h08, 32'd1);
    sample(5000, -8192);
    idle(3);

    // Enable mask and shift change mid-stream
    wr(16'h04, 32'd0);
    wr(16'h00, 32'd1);
    sample(300, 7000);
    wr(16'h00, 32'd3);
    for (int i = 0; i < 6; i++) begin
      step(rand_sample(), rand_sample(), 1'b1, i == 2, 1'b0, 16'h08, 32'd2);
    end
    idle(4);

    // Bus protocol
    wr(16'h08, 32'd3);
    rd(16'h08);
    rd(16'h1C);
    wr(16'h1C, 32'hFFFF_FFFF);
    rd(16'h1C);
    step(0, 0, 1'b0, 1'b1, 1'b1, 16'h08, 32'd5);
    rd(16'h08);
    rd(16'h00);
    rd(16'h04);

    // Counter clear coinciding with the last saturating output
    wr(16'h08, 32'd0);
    repeat (4) sample(8191, 8191);
    rd(16'h0C);
    rd(16'h0C);
    idle(1);
    wr(16'h0C, 32'd0);
    rd(16'h0C);
    idle(2);
    rd(16'h0C);

    // Randomised traffic with interleaved register accesses
    for (int i = 0; i < 400; i++) begin
      int          op;
      bit          w, r;
      logic [15:0] ad;
      op = int'($urandom_range(0, 9));
      w  = (op == 0) || (op == 2);
      r  = (op == 1) || (op == 2);
      ad = 16'($urandom_range(0, 7) << 2);
      step(rand_sample(), rand_sample(), $urandom_range(0, 3) != 0, w, r, ad, $urandom);
    end
    idle(4);

    // Asynchronous reset with three samples still in flight
    wr(16'h08, 32'd2);
    wr(16'h04, 32'd1);
    repeat (4) sample(rand_sample(), rand_sample());
    check_eq("pre_rst_valid", out_valid_o, 1);
    #2;
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    bus.wen    = 1'b0;
    bus.ren    = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    idle(5);
    rd(16'h00); rd(16'h04); rd(16'h08); rd(16'h0C);
    sample(100, -50);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
